amm_arbiter: RTL

AMM_ARBITER -- requirements
Module: amm_arbiter

---
 rtl/amm_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/amm_arbiter.sv
// Two-master Avalon-MM arbiter in front of a DDR controller: round-robin grant,
// write bursts locked to one master, read data steered by a tag FIFO of outstanding bursts.
module amm_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BC_W      = 6,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              local_init_done,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_ren,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BC_W-1:0]   m0_burstcount,
  output logic              m0_wait,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_ren,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BC_W-1:0]   m1_burstcount,
  output logic              m1_wait,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] amm_addr,
  output logic [DATA_W-1:0] amm_wdata,
  output logic [BC_W-1:0]   amm_burstcount,
  output logic              amm_ren,
  output logic              amm_wen,
  input  logic              amm_wait,
  input  logic              amm_rvalid,
  input  logic [DATA_W-1:0] amm_rdata
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WBURST} state_t;

  state_t            state_reg, state_next;
  logic              lock_reg, lock_next;
  logic [BC_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic              rr_last_reg, rr_last_next;

  logic              tag_id_reg [TAG_DEPTH];
  logic [BC_W-1:0]   tag_bc_reg [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [BC_W-1:0]   head_cnt_reg, head_cnt_next;

  logic              active;
  logic [BC_W-1:0]   bc0_eff, bc1_eff;
  logic              fifo_empty, fifo_full;
  logic              head_id;
  logic [BC_W-1:0]   head_bc, head_cnt_inc;
  logic              rd_beat, pop, push, read_ok, accept;
  logic              req_rd0, req_wr0, req_rd1, req_wr1, req0, req1;
  logic              grant_valid, grant_id;

  // Outputs are gated by rst itself so the reset values appear immediately.
  assign active  = rst & local_init_done;
  assign bc0_eff = (m0_burstcount == '0) ? BC_W'(1) : m0_burstcount;
  assign bc1_eff = (m1_burstcount == '0) ? BC_W'(1) : m1_burstcount;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == CNT_W'(TAG_DEPTH));
  assign head_id      = tag_id_reg[rd_ptr_reg];
  assign head_bc      = tag_bc_reg[rd_ptr_reg];
  assign head_cnt_inc = head_cnt_reg + BC_W'(1);
  assign rd_beat      = rst & amm_rvalid & ~fifo_empty;
  assign pop          = rd_beat & (head_cnt_inc == head_bc);

  // A slot freed by this cycle's pop can be reused by this cycle's read.
  assign read_ok = ~fifo_full | pop;
  assign req_rd0 = m0_ren & read_ok;
  assign req_wr0 = ~m0_ren & m0_wen;
  assign req_rd1 = m1_ren & read_ok;
  assign req_wr1 = ~m1_ren & m1_wen;
  assign req0    = req_rd0 | req_wr0;
  assign req1    = req_rd1 | req_wr1;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (active) begin
      if (state_reg == WBURST) begin
        grant_valid = 1'b1;
        grant_id    = lock_reg;
      end else if (req0 && req1) begin
        grant_valid = 1'b1;
        grant_id    = ~rr_last_reg;
      end else if (req0) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  always_comb begin
    amm_ren = 1'b0;
    amm_wen = 1'b0;
    if (grant_valid) begin
      if (state_reg == WBURST) begin
        amm_wen = grant_id ? m1_wen : m0_wen;
      end else begin
        amm_ren = grant_id ? req_rd1 : req_rd0;
        amm_wen = grant_id ? req_wr1 : req_wr0;
      end
    end
  end

  assign amm_addr       = grant_id ? m1_addr : m0_addr;
  assign amm_wdata      = grant_id ? m1_wdata : m0_wdata;
  assign amm_burstcount = grant_id ? bc1_eff : bc0_eff;

  assign m0_wait   = (grant_valid && !grant_id) ? amm_wait : 1'b1;
  assign m1_wait   = (grant_valid &&  grant_id) ? amm_wait : 1'b1;
  assign m0_rvalid = rd_beat & ~head_id;
  assign m1_rvalid = rd_beat &  head_id;
  assign m0_rdata  = amm_rdata;
  assign m1_rdata  = amm_rdata;

  assign accept = (amm_ren | amm_wen) & ~amm_wait;
  assign push   = amm_ren & ~amm_wait;

  always_comb begin
    state_next    = state_reg;
    lock_next     = lock_reg;
    beat_cnt_next = beat_cnt_reg;
    rr_last_next  = rr_last_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          rr_last_next = grant_id;
          if (amm_wen && amm_burstcount > BC_W'(1)) begin
            state_next    = WBURST;
            lock_next     = grant_id;
            beat_cnt_next = amm_burstcount - BC_W'(1);
          end
        end
      end
      WBURST: begin
        if (accept) begin
          beat_cnt_next = beat_cnt_reg - BC_W'(1);
          if (beat_cnt_reg == BC_W'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lock_reg     <= 1'b0;
      beat_cnt_reg <= '0;
      rr_last_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      lock_reg     <= lock_next;
      beat_cnt_reg <= beat_cnt_next;
      rr_last_reg  <= rr_last_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    head_cnt_next = head_cnt_reg;
    if (pop)          head_cnt_next = '0;
    else if (rd_beat) head_cnt_next = head_cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg    <= count_next;
      head_cnt_reg <= head_cnt_next;
    end
  end

  // Tag storage is tiny and the head must be visible in the same cycle, so it lives in flops.
  genvar gi;
  generate
    for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tag_id_reg[gi] <= 1'b0;
          tag_bc_reg[gi] <= '0;
        end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
          tag_id_reg[gi] <= grant_id;
          tag_bc_reg[gi] <= amm_burstcount;
        end
      end
    end
  endgenerate

endmodule
